// File: rtl/clint_pkg.sv
// Shared constants and state encoding for the core-local interrupt controller.
// Holds CSR addresses, SYSTEM instruction encodings and synchronous trap causes.
package clint_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int CAUSE_ECALL  = 11;
    localparam int CAUSE_EBREAK = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_JUMP,
        S_W_MRET,
        S_JUMP_RET
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set request bit
// as both a binary index and a one-hot vector.
module irq_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   index,
    output logic [NUM_IRQ-1:0] onehot
);

    // Scanning from the top down lets the lowest set bit overwrite the others.
    always_comb begin
        valid  = |req;
        index  = '0;
        onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index     = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clint_vec.sv
// Core-local interrupt controller for the ID stage: decodes traps and MRET,
// sequences the mepc/mcause/mstatus writes and redirects the PC.
module clint_vec
    import clint_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int XLEN        = 32,
    parameter int CAUSE_BASE  = 16,
    parameter int VECTORED_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_pending,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [31:0]        inst,
    input  logic [XLEN-1:0]    inst_addr_if,
    input  logic               jump_flag,
    input  logic [XLEN-1:0]    jump_addr,
    input  logic [XLEN-1:0]    csr_mtvec,
    input  logic [XLEN-1:0]    csr_mepc,
    input  logic [XLEN-1:0]    csr_mstatus,
    output logic               ctrl_stall_flag,
    output logic               csr_reg_we,
    output logic [11:0]        csr_reg_wa,
    output logic [XLEN-1:0]    csr_reg_wd,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               id_interrupt_assert,
    output logic [XLEN-1:0]    id_interrupt_handler_addr
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    state_t state, state_next;

    logic               enc_valid;
    logic [IDX_W-1:0]   enc_index;
    logic [NUM_IRQ-1:0] enc_onehot;

    logic sync_req, async_req, mret_req;
    logic [XLEN-1:0] cap_epc, cap_cause;
    logic [XLEN-1:0] epc, cause;
    logic            is_async;
    logic [NUM_IRQ-1:0] ack_line;
    logic [XLEN-1:0] mtvec_base, handler_addr;

    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r    = ms;
        r[3] = ms[7];
        r[7] = 1'b1;
        return r;
    endfunction

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_prio_enc (
        .req    (irq_pending & irq_mask),
        .valid  (enc_valid),
        .index  (enc_index),
        .onehot (enc_onehot)
    );

    assign sync_req  = (inst == INST_ECALL) || (inst == INST_EBREAK);
    assign async_req = enc_valid && csr_mstatus[3];
    assign mret_req  = (inst == INST_MRET);

    assign ctrl_stall_flag = (state != S_IDLE) || sync_req || async_req || mret_req;

    always_comb begin
        cap_epc   = inst_addr_if;
        cap_cause = XLEN'(CAUSE_ECALL);
        if (sync_req) begin
            if (jump_flag)
                cap_epc = jump_addr - XLEN'(4);
            cap_cause = (inst == INST_EBREAK) ? XLEN'(CAUSE_EBREAK) : XLEN'(CAUSE_ECALL);
        end else begin
            if (jump_flag)
                cap_epc = jump_addr;
            cap_cause = {1'b1, {(XLEN-1){1'b0}}} | (XLEN'(CAUSE_BASE) + XLEN'(enc_index));
        end
    end

    // Vectored offset is 4*code; the shift discards the interrupt flag bit.
    assign mtvec_base   = {csr_mtvec[XLEN-1:2], 2'b00};
    assign handler_addr = ((VECTORED_EN != 0) && (csr_mtvec[1:0] == 2'b01) && is_async)
                        ? mtvec_base + (cause << 2)
                        : mtvec_base;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (sync_req || async_req)
                    state_next = S_W_MEPC;
                else if (mret_req)
                    state_next = S_W_MRET;
            end
            S_W_MEPC:    state_next = S_W_MCAUSE;
            S_W_MCAUSE:  state_next = S_W_MSTATUS;
            S_W_MSTATUS: state_next = S_JUMP;
            S_JUMP:      state_next = S_IDLE;
            S_W_MRET:    state_next = S_JUMP_RET;
            S_JUMP_RET:  state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            epc      <= '0;
            cause    <= '0;
            is_async <= 1'b0;
            ack_line <= '0;
        end else if (state == S_IDLE && state_next == S_W_MEPC) begin
            epc      <= cap_epc;
            cause    <= cap_cause;
            is_async <= !sync_req;
            ack_line <= sync_req ? '0 : enc_onehot;
        end
    end

    // Outputs are registered on entry, so each write is visible during its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_reg_we                <= 1'b0;
            csr_reg_wa                <= '0;
            csr_reg_wd                <= '0;
            irq_ack                   <= '0;
            id_interrupt_assert       <= 1'b0;
            id_interrupt_handler_addr <= '0;
        end else begin
            csr_reg_we                <= 1'b0;
            csr_reg_wa                <= '0;
            csr_reg_wd                <= '0;
            irq_ack                   <= '0;
            id_interrupt_assert       <= 1'b0;
            id_interrupt_handler_addr <= '0;
            case (state_next)
                S_W_MEPC: begin
                    csr_reg_we <= 1'b1;
                    csr_reg_wa <= CSR_MEPC;
                    csr_reg_wd <= cap_epc;
                end
                S_W_MCAUSE: begin
                    csr_reg_we <= 1'b1;
                    csr_reg_wa <= CSR_MCAUSE;
                    csr_reg_wd <= cause;
                end
                S_W_MSTATUS: begin
                    csr_reg_we <= 1'b1;
                    csr_reg_wa <= CSR_MSTATUS;
                    csr_reg_wd <= trap_mstatus(csr_mstatus);
                end
                S_JUMP: begin
                    id_interrupt_assert       <= 1'b1;
                    id_interrupt_handler_addr <= handler_addr;
                    irq_ack                   <= is_async ? ack_line : '0;
                end
                S_W_MRET: begin
                    csr_reg_we <= 1'b1;
                    csr_reg_wa <= CSR_MSTATUS;
                    csr_reg_wd <= mret_mstatus(csr_mstatus);
                end
                S_JUMP_RET: begin
                    id_interrupt_assert       <= 1'b1;
                    id_interrupt_handler_addr <= csr_mepc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_vec.sv
// Self-checking bench for clint_vec: decode vectors, directed trap/MRET/reset
// sequences and a randomized run against a transaction-level reference model.
module tb_clint_vec;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_pending, irq_mask;
    logic [31:0] inst, inst_addr_if, jump_addr, csr_mtvec, csr_mepc, csr_mstatus;
    logic        jump_flag;
    logic        ctrl_stall_flag, csr_reg_we, id_interrupt_assert;
    logic [11:0] csr_reg_wa;
    logic [31:0] csr_reg_wd, id_interrupt_handler_addr;
    logic [7:0]  irq_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        asrt;
        logic [31:0] addr;
        logic [7:0]  ack;
        logic        stall;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  pend;
        logic [7:0]  mask;
        logic [31:0] ms;
        logic [31:0] pc;
        logic        jf;
        logic [31:0] ja;
        logic        stall;
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[9];

    clint_vec dut (
        .clk                       (clk),
        .rst                       (rst),
        .irq_pending               (irq_pending),
        .irq_mask                  (irq_mask),
        .inst                      (inst),
        .inst_addr_if              (inst_addr_if),
        .jump_flag                 (jump_flag),
        .jump_addr                 (jump_addr),
        .csr_mtvec                 (csr_mtvec),
        .csr_mepc                  (csr_mepc),
        .csr_mstatus               (csr_mstatus),
        .ctrl_stall_flag           (ctrl_stall_flag),
        .csr_reg_we                (csr_reg_we),
        .csr_reg_wa                (csr_reg_wa),
        .csr_reg_wd                (csr_reg_wd),
        .irq_ack                   (irq_ack),
        .id_interrupt_assert       (id_interrupt_assert),
        .id_interrupt_handler_addr (id_interrupt_handler_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] i, input logic [7:0] pend, input logic [7:0] mask,
                                 input logic [31:0] ms, input logic [31:0] pc, input logic jf,
                                 input logic [31:0] ja);
        inst         = i;
        irq_pending  = pend;
        irq_mask     = mask;
        csr_mstatus  = ms;
        inst_addr_if = pc;
        jump_flag    = jf;
        jump_addr    = ja;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expectCycle(input string tag, input exp_t e);
        checkOutput({tag, ".we"},    32'(csr_reg_we),             32'(e.we));
        checkOutput({tag, ".wa"},    32'(csr_reg_wa),             32'(e.wa));
        checkOutput({tag, ".wd"},    csr_reg_wd,                  e.wd);
        checkOutput({tag, ".asrt"},  32'(id_interrupt_assert),    32'(e.asrt));
        checkOutput({tag, ".addr"},  id_interrupt_handler_addr,   e.addr);
        checkOutput({tag, ".ack"},   32'(irq_ack),                32'(e.ack));
        checkOutput({tag, ".stall"}, 32'(ctrl_stall_flag),        32'(e.stall));
    endtask

    function automatic exp_t mk(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                                input logic asrt, input logic [31:0] addr, input logic [7:0] ack,
                                input logic stall);
        exp_t e;
        e.we = we; e.wa = wa; e.wd = wd; e.asrt = asrt; e.addr = addr; e.ack = ack; e.stall = stall;
        return e;
    endfunction

    // Trap sequence whose request is already on the inputs in the current cycle.
    task automatic runTrap(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] ms_wr, input logic [31:0] addr, input logic [7:0] ack,
                           input logic keep_pend);
        expectCycle({tag, ".t0"}, mk(0, 0, 0, 0, 0, 0, 1));
        tick();
        inst      = NOP;
        jump_flag = 1'b0;
        if (!keep_pend) irq_pending = 8'h00;
        #1;
        expectCycle({tag, ".t1"}, mk(1, 12'h341, epc, 0, 0, 0, 1));
        tick();
        expectCycle({tag, ".t2"}, mk(1, 12'h342, cause, 0, 0, 0, 1));
        tick();
        expectCycle({tag, ".t3"}, mk(1, 12'h300, ms_wr, 0, 0, 0, 1));
        tick();
        expectCycle({tag, ".t4"}, mk(0, 0, 0, 1, addr, ack, 1));
        tick();
    endtask

    function automatic logic [31:0] pickInst();
        case ($urandom_range(0, 11))
            0:       return ECALL;
            1:       return EBREAK;
            2:       return MRET;
            default: return ($urandom & 32'hFFFF_FF00) | 32'h13;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        csr_mtvec = 32'h8000_0001;
        csr_mepc  = 32'h0;
        applyStimulus(NOP, 8'h00, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        expectCycle("reset", mk(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        tick();

        // Decode table: stall in the request cycle and the first write one cycle later.
        vecs[0] = '{NOP,    8'h00, 8'hFF, 32'h08, 32'h40, 1'b0, 32'h0,    1'b0, 1'b0, 12'h000, 32'h0};
        vecs[1] = '{ECALL,  8'h00, 8'hFF, 32'h08, 32'h40, 1'b1, 32'h1000, 1'b1, 1'b1, 12'h341, 32'h0FFC};
        vecs[2] = '{EBREAK, 8'h00, 8'hFF, 32'h08, 32'h44, 1'b0, 32'h1000, 1'b1, 1'b1, 12'h341, 32'h44};
        vecs[3] = '{NOP,    8'h80, 8'h80, 32'h08, 32'h50, 1'b1, 32'h2000, 1'b1, 1'b1, 12'h341, 32'h2000};
        vecs[4] = '{NOP,    8'hF0, 8'h0F, 32'h08, 32'h50, 1'b0, 32'h0,    1'b0, 1'b0, 12'h000, 32'h0};
        vecs[5] = '{MRET,   8'h00, 8'h00, 32'h08, 32'h60, 1'b0, 32'h0,    1'b1, 1'b1, 12'h300, 32'h80};
        vecs[6] = '{MRET,   8'h00, 8'h00, 32'h88, 32'h60, 1'b0, 32'h0,    1'b1, 1'b1, 12'h300, 32'h88};
        vecs[7] = '{ECALL,  8'h01, 8'h01, 32'h08, 32'h70, 1'b0, 32'h0,    1'b1, 1'b1, 12'h341, 32'h70};
        vecs[8] = '{MRET,   8'h02, 8'h02, 32'h08, 32'h74, 1'b1, 32'h3000, 1'b1, 1'b1, 12'h341, 32'h3000};
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].inst, vecs[v].pend, vecs[v].mask, vecs[v].ms,
                          vecs[v].pc, vecs[v].jf, vecs[v].ja);
            checkOutput($sformatf("vec%0d.stall", v), 32'(ctrl_stall_flag), 32'(vecs[v].stall));
            tick();
            applyStimulus(NOP, 8'h00, vecs[v].mask, vecs[v].ms, vecs[v].pc, 1'b0, 32'h0);
            checkOutput($sformatf("vec%0d.we", v), 32'(csr_reg_we), 32'(vecs[v].we));
            checkOutput($sformatf("vec%0d.wa", v), 32'(csr_reg_wa), 32'(vecs[v].wa));
            checkOutput($sformatf("vec%0d.wd", v), csr_reg_wd, vecs[v].wd);
            for (int k = 0; k < 5; k++) tick();
        end

        // ECALL: synchronous traps never use the vectored offset.
        applyStimulus(ECALL, 8'h00, 8'hFF, 32'h08, 32'h100, 1'b0, 32'h0);
        runTrap("ecall", 32'h100, 32'd11, 32'h1880, 32'h8000_0000, 8'h00, 1'b0);
        expectCycle("ecall.t5", mk(0, 0, 0, 0, 0, 0, 0));

        // Line 2 wins over line 3; vectored handler at base + 4*18.
        applyStimulus(NOP, 8'h0C, 8'hFF, 32'h08, 32'h300, 1'b0, 32'h0);
        runTrap("irq2", 32'h300, 32'h8000_0012, 32'h1880, 32'h8000_0048, 8'h04, 1'b0);
        expectCycle("irq2.t5", mk(0, 0, 0, 0, 0, 0, 0));

        // Pending line blocked by MIE=0, then by the mask, then allowed.
        applyStimulus(NOP, 8'h01, 8'hFF, 32'h00, 32'h400, 1'b0, 32'h0);
        expectCycle("mie0", mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        expectCycle("mie0.next", mk(0, 0, 0, 0, 0, 0, 0));
        applyStimulus(NOP, 8'h01, 8'h00, 32'h08, 32'h400, 1'b0, 32'h0);
        expectCycle("mask0", mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        applyStimulus(NOP, 8'h01, 8'h01, 32'h08, 32'h400, 1'b0, 32'h0);
        runTrap("irq0", 32'h400, 32'h8000_0010, 32'h1880, 32'h8000_0040, 8'h01, 1'b0);

        // EBREAK alongside a pending line: sync first, the line follows from IDLE.
        applyStimulus(EBREAK, 8'h01, 8'h01, 32'h08, 32'h500, 1'b0, 32'h0);
        runTrap("ebrk", 32'h500, 32'd3, 32'h1880, 32'h8000_0000, 8'h00, 1'b1);
        inst_addr_if = 32'h504;
        #1;
        runTrap("ebrk.irq", 32'h504, 32'h8000_0010, 32'h1880, 32'h8000_0040, 8'h01, 1'b0);

        // MRET restores MIE from MPIE and returns to mepc two cycles later.
        csr_mepc = 32'h200;
        applyStimulus(MRET, 8'h00, 8'h00, 32'h80, 32'h600, 1'b0, 32'h0);
        expectCycle("mret.t0", mk(0, 0, 0, 0, 0, 0, 1));
        tick();
        inst = NOP;
        #1;
        expectCycle("mret.t1", mk(1, 12'h300, 32'h88, 0, 0, 0, 1));
        tick();
        expectCycle("mret.t2", mk(0, 0, 0, 1, 32'h200, 0, 1));
        tick();
        expectCycle("mret.t3", mk(0, 0, 0, 0, 0, 0, 0));

        // Reset during W_MCAUSE aborts the sequence.
        applyStimulus(ECALL, 8'h00, 8'h00, 32'h08, 32'h100, 1'b0, 32'h0);
        tick();
        inst = NOP;
        #1;
        expectCycle("rst.t1", mk(1, 12'h341, 32'h100, 0, 0, 0, 1));
        tick();
        expectCycle("rst.t2", mk(1, 12'h342, 32'd11, 0, 0, 0, 1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        expectCycle("rst.t3", mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        expectCycle("rst.t4", mk(0, 0, 0, 0, 0, 0, 0));
        applyStimulus(ECALL, 8'h00, 8'h00, 32'h08, 32'h100, 1'b0, 32'h0);
        runTrap("rst.fresh", 32'h100, 32'd11, 32'h1880, 32'h8000_0000, 8'h00, 1'b0);

        // Randomized run: the model schedules the per-cycle outputs of each accepted request.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            bit          idle, sreq, areq, mreq;
            exp_t        e;
            logic [7:0]  act, lsb;
            logic [31:0] epc, cause, base, addr, code, ms;
            idle = (exp_q.size() == 0);
            if (idle) begin
                csr_mtvec   = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
                csr_mstatus = $urandom;
                csr_mepc    = $urandom;
            end
            inst         = pickInst();
            irq_pending  = 8'($urandom) & 8'($urandom);
            irq_mask     = 8'($urandom) & 8'($urandom);
            inst_addr_if = $urandom;
            jump_flag    = 1'($urandom);
            jump_addr    = $urandom;
            #1;
            act  = irq_pending & irq_mask;
            sreq = (inst == ECALL) || (inst == EBREAK);
            areq = (act != 0) && csr_mstatus[3];
            mreq = (inst == MRET);
            if (!idle) e = exp_q.pop_front();
            else       e = mk(0, 0, 0, 0, 0, 0, sreq | areq | mreq);
            expectCycle($sformatf("rnd%0d", c), e);
            if (idle && (sreq || areq)) begin
                ms   = csr_mstatus;
                base = csr_mtvec & 32'hFFFF_FFFC;
                if (sreq) begin
                    epc   = jump_flag ? jump_addr - 32'd4 : inst_addr_if;
                    cause = (inst == EBREAK) ? 32'd3 : 32'd11;
                    addr  = base;
                    lsb   = 8'h00;
                end else begin
                    lsb   = act & (~act + 8'd1);
                    code  = 32'd16 + 32'($clog2(lsb));
                    epc   = jump_flag ? jump_addr : inst_addr_if;
                    cause = 32'h8000_0000 | code;
                    addr  = (csr_mtvec[1:0] == 2'b01) ? base + 32'd4 * code : base;
                end
                exp_q.push_back(mk(1, 12'h341, epc, 0, 0, 0, 1));
                exp_q.push_back(mk(1, 12'h342, cause, 0, 0, 0, 1));
                exp_q.push_back(mk(1, 12'h300,
                    (ms & ~32'h1888) | 32'h1800 | (ms[3] ? 32'h80 : 32'h0), 0, 0, 0, 1));
                exp_q.push_back(mk(0, 0, 0, 1, addr, lsb, 1));
            end else if (idle && mreq) begin
                ms = csr_mstatus;
                exp_q.push_back(mk(1, 12'h300,
                    (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0), 0, 0, 0, 1));
                exp_q.push_back(mk(0, 0, 0, 1, csr_mepc, 0, 1));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
